msp430_sequencer: RTL and testbench

- Multi-cycle control FSM for the MSP430 CPU core.
- Fetches each instruction word and decodes Format I (two-operand), Format II (one-operand) and Format III (jump).
- Drives every control input of the register file (MO, operand addresses, addressing modes, auto-increment, write-back, SR update, branch) and the memory read/write strobes.
- Sits between the memory bus, the register file and the function unit; one instruction in flight at a time.

---
 rtl/msp430_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_msp430_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msp430_sequencer.sv
// msp430_sequencer: multi-cycle fetch/decode/execute control FSM for the MSP430 core.
// One instruction in flight; drives register-file controls and memory strobes.
module msp430_sequencer #(
    parameter int unsigned RESET_STALL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mdb_in,
    input  logic        mem_ready,
    input  logic        Zcurrent,
    input  logic        Vcurrent,
    input  logic        Ncurrent,
    input  logic        Ccurrent,
    input  logic [15:0] PC,
    output logic [1:0]  MO,
    output logic [3:0]  srcA,
    output logic [3:0]  dstA,
    output logic [1:0]  As,
    output logic        Ad,
    output logic        OneOp,
    output logic        BW,
    output logic        incSrc,
    output logic        incDst,
    output logic        indirect,
    output logic        RW,
    output logic [3:0]  resultA,
    output logic        SRW,
    output logic        BranchExecute,
    output logic [15:0] BranchAddress,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [3:0]  fu_op,
    output logic [15:0] ir,
    output logic [15:0] offset_reg
);

    localparam int unsigned CNT_W = (RESET_STALL < 1) ? 1 : $clog2(RESET_STALL + 1);

    localparam logic [1:0] MO_NOP    = 2'd0;
    localparam logic [1:0] MO_NEXT   = 2'd1;
    localparam logic [1:0] MO_OFFSET = 2'd2;
    localparam logic [1:0] MO_PREDEC = 2'd3;

    typedef enum logic [3:0] {
        ST_STALL,
        ST_FETCH,
        ST_DECODE,
        ST_SRC_OFF,
        ST_SRC_RD,
        ST_DST_OFF,
        ST_DST_RD,
        ST_EXEC,
        ST_DST_WR,
        ST_PUSH,
        ST_JUMP
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [CNT_W-1:0]   stallCnt;
    logic               pushMoDone;
    logic               irLoad;
    logic               offLoad;

    logic               isJump;
    logic               isFmt2;
    logic               isFmt1;
    logic [3:0]         opReg;
    logic [3:0]         opcode;
    logic [2:0]         fmt2Op;
    logic               isPush;
    logic               fmt2Wb;
    logic               isCmpBit;
    logic               srwEn;
    logic               cgSrc;
    logic               needSrcOff;
    logic               needSrcRd;
    logic               jumpTaken;
    logic [15:0]        jumpOff;
    state_t             afterSrc;

    // Instruction field breakout from the latched IR
    assign srcA   = ir[11:8];
    assign dstA   = ir[3:0];
    assign As     = ir[5:4];
    assign Ad     = ir[7];
    assign BW     = ir[6];
    assign OneOp  = isFmt2;
    assign opcode = ir[15:12];
    assign fmt2Op = ir[9:7];
    assign fu_op  = isFmt2 ? {1'b0, ir[9:7]} : ir[15:12];

    // Format classification and operand-path decisions
    always_comb begin
        isJump     = (ir[15:13] == 3'b001);
        isFmt2     = (ir[15:10] == 6'b000100);
        isFmt1     = (ir[15:12] >= 4'd4);
        // Format II keeps its single operand register in the low nibble
        opReg      = isFmt2 ? ir[3:0] : ir[11:8];
        isPush     = isFmt2 && (fmt2Op == 3'b100);
        fmt2Wb     = isFmt2 && !fmt2Op[2];
        isCmpBit   = isFmt1 && ((opcode == 4'h9) || (opcode == 4'hB));
        srwEn      = isFmt1 ? !((opcode == 4'h4) || (opcode == 4'hC) || (opcode == 4'hD))
                            : (isFmt2 && ((fmt2Op == 3'b000) || (fmt2Op == 3'b010) || (fmt2Op == 3'b011)));
        // R3 is always a constant generator, R2 only in the indirect modes
        cgSrc      = (opReg == 4'd3) || ((opReg == 4'd2) && ir[5]);
        needSrcOff = (ir[5:4] == 2'b01) && (opReg != 4'd3);
        needSrcRd  = ir[5] && !cgSrc;
        afterSrc   = (isFmt1 && ir[7]) ? ST_DST_OFF : ST_EXEC;
    end

    // Jump condition and sign-extended word offset
    always_comb begin
        jumpOff = {{5{ir[9]}}, ir[9:0], 1'b0};
        case (ir[12:10])
            3'b000:  jumpTaken = !Zcurrent;
            3'b001:  jumpTaken = Zcurrent;
            3'b010:  jumpTaken = !Ccurrent;
            3'b011:  jumpTaken = Ccurrent;
            3'b100:  jumpTaken = Ncurrent;
            3'b101:  jumpTaken = !(Ncurrent ^ Vcurrent);
            3'b110:  jumpTaken = Ncurrent ^ Vcurrent;
            default: jumpTaken = 1'b1;
        endcase
    end

    // State register, stall counter, IR and offset latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_STALL;
            stallCnt   <= CNT_W'(RESET_STALL);
            ir         <= 16'h4303;
            offset_reg <= 16'h0000;
            pushMoDone <= 1'b0;
        end else begin
            state <= nextState;
            if ((state == ST_STALL) && (stallCnt != '0)) begin
                stallCnt <= stallCnt - CNT_W'(1);
            end
            if (irLoad) begin
                ir <= mdb_in;
            end
            if (offLoad) begin
                offset_reg <= mdb_in;
            end
            pushMoDone <= (state == ST_PUSH) && (nextState == ST_PUSH);
        end
    end

    // Next-state and control strobes
    always_comb begin
        nextState     = state;
        MO            = MO_NOP;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        indirect      = 1'b0;
        incSrc        = 1'b0;
        incDst        = 1'b0;
        RW            = 1'b0;
        resultA       = 4'd0;
        SRW           = 1'b0;
        BranchExecute = 1'b0;
        BranchAddress = 16'h0000;
        irLoad        = 1'b0;
        offLoad       = 1'b0;

        case (state)
            ST_STALL: begin
                if (stallCnt == '0) begin
                    nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    MO        = MO_NEXT;
                    irLoad    = 1'b1;
                    nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (isJump) begin
                    nextState = ST_JUMP;
                end else if (isFmt1 || isFmt2) begin
                    if (needSrcOff) begin
                        nextState = ST_SRC_OFF;
                    end else if (needSrcRd) begin
                        nextState = ST_SRC_RD;
                    end else begin
                        nextState = afterSrc;
                    end
                end else begin
                    nextState = ST_FETCH;
                end
            end
            ST_SRC_OFF: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    MO        = MO_OFFSET;
                    offLoad   = 1'b1;
                    nextState = ST_SRC_RD;
                end
            end
            ST_SRC_RD: begin
                mem_rd   = 1'b1;
                indirect = ir[5];
                if (mem_ready) begin
                    incSrc    = isFmt1 && (ir[5:4] == 2'b11) && !cgSrc;
                    incDst    = isFmt2 && (ir[5:4] == 2'b11) && !cgSrc;
                    nextState = afterSrc;
                end
            end
            ST_DST_OFF: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    MO        = MO_OFFSET;
                    offLoad   = 1'b1;
                    nextState = ST_DST_RD;
                end
            end
            ST_DST_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    nextState = ST_EXEC;
                end
            end
            ST_EXEC: begin
                SRW       = srwEn;
                nextState = ST_FETCH;
                if (isPush) begin
                    nextState = ST_PUSH;
                end else if (isFmt1) begin
                    if (ir[7]) begin
                        nextState = isCmpBit ? ST_FETCH : ST_DST_WR;
                    end else if (!isCmpBit) begin
                        RW      = 1'b1;
                        resultA = dstA;
                    end
                end else if (fmt2Wb) begin
                    if (ir[5:4] == 2'b00) begin
                        RW      = 1'b1;
                        resultA = dstA;
                    end else begin
                        nextState = ST_DST_WR;
                    end
                end
            end
            ST_DST_WR: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    nextState = ST_FETCH;
                end
            end
            ST_PUSH: begin
                // First cycle pre-decrements SP, then the write is held until accepted
                if (!pushMoDone) begin
                    MO = MO_PREDEC;
                end else begin
                    mem_wr = 1'b1;
                    if (mem_ready) begin
                        nextState = ST_FETCH;
                    end
                end
            end
            ST_JUMP: begin
                BranchAddress = PC + jumpOff;
                BranchExecute = jumpTaken;
                nextState     = ST_FETCH;
            end
            default: begin
                nextState = ST_STALL;
            end
        endcase
    end

endmodule

// File: tb/tb_msp430_sequencer.sv
// Scoreboard bench for msp430_sequencer: directed instructions, expected events queued
// at issue time and checked by an independent monitor.
module tb_msp430_sequencer;

    typedef struct packed {
        logic [1:0]  mo;
        logic        rd;
        logic        ind;
        logic        incS;
        logic        rw;
        logic [3:0]  ra;
        logic        srw;
        logic        br;
        logic [15:0] ba;
        logic        wr;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [15:0] mdb_in;
    logic        mem_ready;
    logic        Zcurrent, Vcurrent, Ncurrent, Ccurrent;
    logic [15:0] PC;
    logic [1:0]  MO;
    logic [3:0]  srcA, dstA;
    logic [1:0]  As;
    logic        Ad, OneOp, BW, incSrc, incDst, indirect, RW;
    logic [3:0]  resultA;
    logic        SRW, BranchExecute;
    logic [15:0] BranchAddress;
    logic        mem_rd, mem_wr;
    logic [3:0]  fu_op;
    logic [15:0] ir, offset_reg;

    logic [15:0] rdQ[$];
    ev_t         expQ[$];
    int          wrDelay;
    int          wrCnt;
    int          cyc;
    int          lastFetch, prevFetch;
    int          wrRun, lastWrLen;
    int          sbTotal, sbBad;
    int          dTotal, dBad;

    msp430_sequencer #(.RESET_STALL(2)) dut (
        .clk(clk), .reset(reset), .mdb_in(mdb_in), .mem_ready(mem_ready),
        .Zcurrent(Zcurrent), .Vcurrent(Vcurrent), .Ncurrent(Ncurrent), .Ccurrent(Ccurrent),
        .PC(PC), .MO(MO), .srcA(srcA), .dstA(dstA), .As(As), .Ad(Ad), .OneOp(OneOp), .BW(BW),
        .incSrc(incSrc), .incDst(incDst), .indirect(indirect), .RW(RW), .resultA(resultA),
        .SRW(SRW), .BranchExecute(BranchExecute), .BranchAddress(BranchAddress),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .fu_op(fu_op), .ir(ir), .offset_reg(offset_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [1:0] mo, input logic rd, input logic ind,
                               input logic inc, input logic rw, input logic [3:0] ra,
                               input logic srw, input logic br, input logic [15:0] ba,
                               input logic wr);
        ev_t e;
        e.mo = mo; e.rd = rd; e.ind = ind; e.incS = inc; e.rw = rw; e.ra = ra;
        e.srw = srw; e.br = br; e.ba = ba; e.wr = wr;
        return e;
    endfunction

    // Memory model: serves queued words to reads, accepts writes after wrDelay wait cycles
    always @(negedge clk) begin
        if (reset) begin
            mem_ready = 1'b0;
            wrCnt     = 0;
        end else if (mem_rd) begin
            if (rdQ.size() > 0) begin
                mdb_in    = rdQ[0];
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
            end
        end else if (mem_wr) begin
            if (wrCnt >= wrDelay) begin
                mem_ready = 1'b1;
                wrCnt     = 0;
            end else begin
                mem_ready = 1'b0;
                wrCnt     = wrCnt + 1;
            end
        end else begin
            mem_ready = 1'b0;
        end
        #1;
        if (!reset && mem_rd && mem_ready && rdQ.size() > 0) rdQ.delete(0);
    end

    // Monitor: every cycle with a visible effect is popped against the scoreboard
    always @(negedge clk) begin
        ev_t o;
        ev_t e;
        #1;
        if (!reset) begin
            if (mem_wr) wrRun = wrRun + 1;
            else        wrRun = 0;
            o.mo   = MO;
            o.rd   = mem_rd && mem_ready && (MO == 2'd0);
            o.ind  = indirect;
            o.incS = incSrc;
            o.rw   = RW;
            o.ra   = RW ? resultA : 4'd0;
            o.srw  = SRW;
            o.br   = BranchExecute;
            o.ba   = BranchExecute ? BranchAddress : 16'h0000;
            o.wr   = mem_wr && mem_ready;
            if (o.wr) begin
                lastWrLen = wrRun;
                wrRun     = 0;
            end
            if (o.mo != 2'd0 || o.rd || o.rw || o.srw || o.br || o.wr) begin
                sbTotal = sbTotal + 1;
                if (MO == 2'd1) begin
                    prevFetch = lastFetch;
                    lastFetch = cyc;
                end
                if (expQ.size() == 0) begin
                    sbBad = sbBad + 1;
                    $display("FAIL unexpected_event at cyc %0d got mo=%0d rd=%0d ind=%0d inc=%0d rw=%0d ra=%0d srw=%0d br=%0d ba=%h wr=%0d",
                             cyc, o.mo, o.rd, o.ind, o.incS, o.rw, o.ra, o.srw, o.br, o.ba, o.wr);
                end else begin
                    e = expQ.pop_front();
                    if (o !== e) begin
                        sbBad = sbBad + 1;
                        $display("FAIL event at cyc %0d got mo=%0d rd=%0d ind=%0d inc=%0d rw=%0d ra=%0d srw=%0d br=%0d ba=%h wr=%0d want mo=%0d rd=%0d ind=%0d inc=%0d rw=%0d ra=%0d srw=%0d br=%0d ba=%h wr=%0d",
                                 cyc, o.mo, o.rd, o.ind, o.incS, o.rw, o.ra, o.srw, o.br, o.ba, o.wr,
                                 e.mo, e.rd, e.ind, e.incS, e.rw, e.ra, e.srw, e.br, e.ba, e.wr);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        dTotal = dTotal + 1;
        if (got !== want) begin
            dBad = dBad + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Wait for all queued words and events to be consumed, bounded
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || rdQ.size() != 0) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            dTotal = dTotal + 1;
            dBad   = dBad + 1;
            $display("FAIL %s timeout got exp_left=%0d rd_left=%0d want 0", name, expQ.size(), rdQ.size());
            expQ.delete();
            rdQ.delete();
        end
        repeat (4) @(negedge clk);
        #2;
    endtask

    function automatic ev_t evFetch();
        return mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0);
    endfunction

    initial begin
        int n;
        reset = 1'b1; mdb_in = 16'h0; mem_ready = 1'b0; PC = 16'h0;
        Zcurrent = 1'b0; Vcurrent = 1'b0; Ncurrent = 1'b0; Ccurrent = 1'b0;
        wrDelay = 0; wrCnt = 0; cyc = 0; lastFetch = 0; prevFetch = 0;
        wrRun = 0; lastWrLen = 0; sbTotal = 0; sbBad = 0; dTotal = 0; dBad = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("reset_strobes", 32'({MO, mem_rd, mem_wr, RW, SRW, BranchExecute, incSrc, incDst, indirect}), 32'h0);
        chk("reset_branch_addr", 32'(BranchAddress), 32'h0);
        chk("reset_ir", 32'(ir), 32'h4303);
        chk("reset_offset", 32'(offset_reg), 32'h0);

        // Stall: first fetch strobe on the third clock after release
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_mem_rd_clk%0d", i + 1), 32'(mem_rd), (i == 2) ? 32'd1 : 32'd0);
        end

        // MOV R4,R5 twice: RW to R5, no SR update, fetch-to-fetch spacing 3
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(evFetch());
            expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 16'h0, 1'b0));
        end
        rdQ.push_back(16'h4405);
        rdQ.push_back(16'h4405);
        drain("mov_reg");
        chk("mov_fetch_spacing", 32'(lastFetch - prevFetch), 32'd3);

        // ADD 0x10(R4),R5: one offset fetch, direct operand read, flags and write-back
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        expQ.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 16'h0, 1'b0));
        rdQ.push_back(16'h5415); rdQ.push_back(16'h0010); rdQ.push_back(16'hABCD);
        drain("add_indexed");
        chk("add_offset_reg", 32'(offset_reg), 32'h0010);

        // MOV @R5+,R6: indirect read with auto-increment, no offset
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 16'h0, 1'b0));
        rdQ.push_back(16'h4536); rdQ.push_back(16'h5555);
        drain("mov_autoinc");
        chk("mov_autoinc_bw", 32'(BW), 32'd0);

        // CMP R4,R5: flags only
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0));
        rdQ.push_back(16'h9405);
        drain("cmp");

        // Illegal word behaves as NOP
        expQ.push_back(evFetch());
        rdQ.push_back(16'h0000);
        drain("illegal");

        // MOV R4,2(R5): dst offset, dst read, memory write-back
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        expQ.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1));
        rdQ.push_back(16'h4485); rdQ.push_back(16'h0002); rdQ.push_back(16'h1111);
        drain("mov_dst_indexed");
        chk("dst_offset_reg", 32'(offset_reg), 32'h0002);

        // JZ +5 taken and not taken
        PC = 16'h1002;
        Zcurrent = 1'b1;
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h100C, 1'b0));
        rdQ.push_back(16'h2405);
        drain("jz_taken");
        Zcurrent = 1'b0;
        expQ.push_back(evFetch());
        rdQ.push_back(16'h2405);
        drain("jz_not_taken");

        // JMP -1 from PC=0 wraps to 0xFFFE
        PC = 16'h0000;
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'hFFFE, 1'b0));
        rdQ.push_back(16'h3FFF);
        drain("jmp_wrap");

        // PUSH R4 with a slow write: one SP pre-decrement, write held 3 cycles
        wrDelay = 2;
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1));
        rdQ.push_back(16'h1204);
        drain("push");
        chk("push_wr_len", 32'(lastWrLen), 32'd3);

        // PUSH aborted by reset while the write is pending
        wrDelay = 1000;
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0));
        rdQ.push_back(16'h1204);
        n = 0;
        while (!mem_wr && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("push_abort_wr_seen", 32'(mem_wr), 32'd1);
        repeat (2) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_mem_wr", 32'(mem_wr), 32'd0);
        chk("abort_strobes", 32'({MO, mem_rd, RW, SRW, BranchExecute}), 32'h0);
        chk("abort_ir", 32'(ir), 32'h4303);
        @(negedge clk);
        wrDelay = 0;
        reset = 1'b0;
        #2;
        chk("abort_stall_mem_rd", 32'(mem_rd), 32'd0);

        // Recovery: ordinary instruction after the abort
        expQ.push_back(evFetch());
        expQ.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 16'h0, 1'b0));
        rdQ.push_back(16'h4405);
        drain("recover");

        $display("test done: total=%0d bad=%0d", sbTotal + dTotal, sbBad + dBad);
        $finish;
    end

endmodule
